spi_slave_spr: RTL and testbench

SPI slave front end with an embedded 256×8 single-port RAM, clocked directly by the system clock. Each slave-select (`SS_n`) frame carries one command bit followed by a 10-bit word: a 2-bit opcode and an 8-bit payload. Supported operations are write address, write data, read address and read data. Read data is returned serially on `MISO`, MSB first. The block is a self-contained memory-mapped peripheral reachable over a 4-wire SPI link.

---
 rtl/spi_spr_pkg.sv | 21 ++
 rtl/spr_ram.sv | 65 ++++++
 rtl/spi_slave_spr.sv | 101 ++++++++++
 tb/tb_spi_slave_spr.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/spi_spr_pkg.sv
// Shared definitions for the SPI slave with embedded single-port RAM:
// FSM state encoding, RAM opcodes and default sizes.
package spi_spr_pkg;

    localparam int MEM_DEPTH_DEF = 256;
    localparam int ADDR_SIZE_DEF = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } state_e;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

endpackage

// File: rtl/spr_ram.sv
// Single-port RAM with separate write/read address registers, driven by
// decoded SPI words. SPR_MEM_CLEAR_ON_RESET_EN zeroes the array on reset.
module spr_ram
    import spi_spr_pkg::*;
#(
    parameter int MEM_DEPTH = MEM_DEPTH_DEF,
    parameter int ADDR_SIZE = ADDR_SIZE_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_SIZE+1:0] din,
    input  logic                 rx_valid,
    output logic [ADDR_SIZE-1:0] dout,
    output logic                 tx_valid
);

    logic [ADDR_SIZE-1:0] mem [MEM_DEPTH];
    logic [ADDR_SIZE-1:0] wr_addr;
    logic [ADDR_SIZE-1:0] rd_addr;
    logic [1:0]           op;
    logic [ADDR_SIZE-1:0] payload;
    logic                 mem_we;

    assign op      = din[ADDR_SIZE+1:ADDR_SIZE];
    assign payload = din[ADDR_SIZE-1:0];
    // rx_valid can still be high on the reset edge; reset must win
    assign mem_we  = !rst && rx_valid && (op == OP_WR_DATA);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_addr  <= '0;
            rd_addr  <= '0;
            dout     <= '0;
            tx_valid <= 1'b0;
        end else begin
            tx_valid <= 1'b0;
            if (rx_valid) begin
                case (op)
                    OP_WR_ADDR: wr_addr <= payload;
                    OP_RD_ADDR: rd_addr <= payload;
                    OP_RD_DATA: begin
                        dout     <= mem[rd_addr];
                        tx_valid <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef SPR_MEM_CLEAR_ON_RESET_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
        end else if (mem_we) begin
            mem[wr_addr] <= payload;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_addr] <= payload;
    end
`endif

endmodule

// File: rtl/spi_slave_spr.sv
// SPI slave front end: command/word deserialiser FSM and MISO serialiser
// around spr_ram. SPR_MEM_CLEAR_ON_RESET_EN is honoured inside spr_ram.
module spi_slave_spr
    import spi_spr_pkg::*;
#(
    parameter int MEM_DEPTH = MEM_DEPTH_DEF,
    parameter int ADDR_SIZE = ADDR_SIZE_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic SS_n,
    input  logic MOSI,
    output logic MISO
);

    localparam int FRAME_BITS = ADDR_SIZE + 2;
    localparam int CW         = $clog2(FRAME_BITS + 1);
    localparam int TW         = $clog2(ADDR_SIZE);
    localparam logic [CW-1:0] RX_LAST = CW'(FRAME_BITS - 1);
    localparam logic [CW-1:0] RX_FULL = CW'(FRAME_BITS);
    localparam logic [TW-1:0] TX_REST = TW'(ADDR_SIZE - 1);

    state_e               state;
    logic [FRAME_BITS-1:0] din;
    logic [CW-1:0]        rx_cnt;
    logic                 rx_valid;
    logic                 rd_addr_ok;
    logic [ADDR_SIZE-1:0] dout;
    logic                 tx_valid;
    logic [ADDR_SIZE-1:0] tx_sr;
    logic [TW-1:0]        tx_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            din      <= '0;
            rx_cnt   <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (SS_n) begin
                state  <= IDLE;
                rx_cnt <= '0;
            end else begin
                case (state)
                    IDLE:    state <= CHK_CMD;
                    CHK_CMD: state <= !MOSI ? WRITE : (rd_addr_ok ? READ_DATA : READ_ADD);
                    default: begin
                        // after a full word the frame is spent until SS_n rises
                        if (rx_cnt != RX_FULL) begin
                            din      <= {din[FRAME_BITS-2:0], MOSI};
                            rx_cnt   <= rx_cnt + 1'b1;
                            rx_valid <= (rx_cnt == RX_LAST);
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            rd_addr_ok <= 1'b0;
        else if (rx_valid && din[FRAME_BITS-1 -: 2] == OP_RD_ADDR)
            rd_addr_ok <= 1'b1;
        else if (rx_valid && din[FRAME_BITS-1 -: 2] == OP_RD_DATA)
            rd_addr_ok <= 1'b0;
    end

    // MISO keeps its last bit both after a full readout and after an abort
    always_ff @(posedge clk) begin
        if (rst) begin
            MISO   <= 1'b0;
            tx_sr  <= '0;
            tx_cnt <= '0;
        end else if (SS_n) begin
            tx_cnt <= '0;
        end else if (tx_valid) begin
            MISO   <= dout[ADDR_SIZE-1];
            tx_sr  <= {dout[ADDR_SIZE-2:0], 1'b0};
            tx_cnt <= TX_REST;
        end else if (tx_cnt != '0) begin
            MISO   <= tx_sr[ADDR_SIZE-1];
            tx_sr  <= {tx_sr[ADDR_SIZE-2:0], 1'b0};
            tx_cnt <= tx_cnt - 1'b1;
        end
    end

    spr_ram #(
        .MEM_DEPTH(MEM_DEPTH),
        .ADDR_SIZE(ADDR_SIZE)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .din     (din),
        .rx_valid(rx_valid),
        .dout    (dout),
        .tx_valid(tx_valid)
    );

endmodule

// File: tb/tb_spi_slave_spr.sv
// Directed bench for spi_slave_spr: frame-level memory model predicts MISO
// every cycle; literal readback values pin the model.
module tb_spi_slave_spr;
    import spi_spr_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ss_n = 1'b1;
    logic mosi = 1'b0;
    logic miso;

    int n_chk = 0;
    int n_fail = 0;

    logic       exp_miso = 1'b0;
    logic [7:0] m_mem [256];
    logic [7:0] m_wa = 8'h00;
    logic [7:0] m_ra = 8'h00;
    logic       m_rdok = 1'b0;

    spi_slave_spr dut (
        .clk (clk),
        .rst (rst),
        .SS_n(ss_n),
        .MOSI(mosi),
        .MISO(miso)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, act, req);
        end
    endtask

    task automatic model_reset();
        m_wa     = 8'h00;
        m_ra     = 8'h00;
        m_rdok   = 1'b0;
        exp_miso = 1'b0;
`ifdef SPR_MEM_CLEAR_ON_RESET_EN
        for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
`endif
    endtask

    // starts and ends at a falling edge; nb payload bits (<10 = aborted frame);
    // rst_k >= 0 asserts reset after readout bit rst_k
    task automatic frame(input bit cmd, input logic [9:0] w, input int nb,
                         input int rst_k, output logic [7:0] got);
        logic [7:0] data;
        got  = 8'h00;
        data = 8'h00;
        ss_n = 1'b0;
        @(posedge clk);
        @(negedge clk) mosi = cmd;
        @(posedge clk);
        for (int i = 0; i < nb; i++) begin
            @(negedge clk) mosi = w[9-i];
            @(posedge clk);
        end
        if (nb == 10) begin
            @(posedge clk);
            case (w[9:8])
                2'b00: m_wa = w[7:0];
                2'b01: m_mem[m_wa] = w[7:0];
                2'b10: begin m_ra = w[7:0]; m_rdok = 1'b1; end
                default: begin data = m_mem[m_ra]; m_rdok = 1'b0; end
            endcase
            if (w[9:8] == 2'b11) begin
                @(negedge clk);
                for (int k = 0; k < 8; k++) begin
                    @(posedge clk) exp_miso = data[7-k];
                    @(negedge clk) got = {got[6:0], miso};
                    if (k == rst_k) begin
                        rst  = 1'b1;
                        ss_n = 1'b1;
                        @(posedge clk) model_reset();
                        @(negedge clk) rst = 1'b0;
                        return;
                    end
                end
            end
        end
        @(negedge clk) ss_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("miso", miso, exp_miso);
        end
    end

    initial begin
        logic [7:0] g;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        chk("rst_state", dut.state, IDLE);
        chk("rst_rdok", dut.rd_addr_ok, 1'b0);
        chk("rst_miso", miso, 1'b0);

        frame(1'b0, 10'b00_10010011, 10, -1, g);
        frame(1'b0, 10'b01_10101011, 10, -1, g);
        frame(1'b1, 10'b10_10010011, 10, -1, g);
        chk("rdok_set", dut.rd_addr_ok, m_rdok);
        chk("rdok_set_lit", dut.rd_addr_ok, 1'b1);
        frame(1'b1, 10'b11_00000001, 10, -1, g);
        chk("rd93_lit", g, 8'hAB);
        chk("rdok_clr", dut.rd_addr_ok, 1'b0);

        // read data with rd_addr_ok=0 goes through READ_ADD
        frame(1'b1, 10'b11_00000000, 10, -1, g);
        chk("rd93_again", g, 8'hAB);
        chk("rdok_still0", dut.rd_addr_ok, m_rdok);

        frame(1'b0, 10'b00_00010000, 10, -1, g);
        frame(1'b0, 10'b01_00010001, 10, -1, g);
        frame(1'b0, 10'b01_01110111, 5, -1, g);
        chk("abort_idle", dut.state, IDLE);
        frame(1'b1, 10'b10_00010000, 10, -1, g);
        frame(1'b1, 10'b11_00000000, 10, -1, g);
        chk("rd10_lit", g, 8'h11);

        frame(1'b0, 10'b00_11111111, 10, -1, g);
        frame(1'b0, 10'b01_01011010, 10, -1, g);
        frame(1'b0, 10'b00_00000000, 10, -1, g);
        frame(1'b0, 10'b01_01011010, 10, -1, g);
        frame(1'b1, 10'b10_11111111, 10, -1, g);
        frame(1'b1, 10'b11_00000000, 10, -1, g);
        chk("rdff_lit", g, 8'h5A);
        frame(1'b1, 10'b10_00000000, 10, -1, g);
        frame(1'b1, 10'b11_00000000, 10, -1, g);
        chk("rd00_lit", g, 8'h5A);
        frame(1'b1, 10'b10_10010011, 10, -1, g);
        frame(1'b1, 10'b11_00000000, 10, -1, g);
        chk("rd93_kept", g, 8'hAB);

        // reset in the middle of a readout
        frame(1'b1, 10'b10_10010011, 10, -1, g);
        frame(1'b1, 10'b11_00000000, 10, 3, g);
        chk("midrst_state", dut.state, IDLE);
        chk("midrst_miso", miso, 1'b0);
        chk("midrst_rdok", dut.rd_addr_ok, 1'b0);
        frame(1'b1, 10'b10_10010011, 10, -1, g);
        frame(1'b1, 10'b11_00000000, 10, -1, g);
`ifdef SPR_MEM_CLEAR_ON_RESET_EN
        chk("post_rst_rd93", g, 8'h00);
`else
        chk("post_rst_rd93", g, 8'hAB);
`endif
        frame(1'b0, 10'b01_00111100, 10, -1, g);
        frame(1'b1, 10'b10_00000000, 10, -1, g);
        frame(1'b1, 10'b11_00000000, 10, -1, g);
        chk("post_rst_wr0", g, 8'h3C);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
